// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared priority-queue entry type, capacity and command encoding
package pq_pkg;

  localparam int KEY_WIDTH   = 8;
  localparam int VAL_WIDTH   = 8;
  localparam int PQ_CAPACITY = 8;
  localparam int KV_W        = KEY_WIDTH + VAL_WIDTH;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_ENQ  = 2'd1,
    OP_DEQ  = 2'd2,
    OP_REPL = 2'd3
  } pq_op_t;

  typedef enum logic [2:0] {
    ST_ARB,
    ST_ISSUE,
    ST_HOLD,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  // NOP is never legal; it only earns an error response.
  function automatic logic op_is_legal(pq_op_t op, logic full, logic empty);
    case (op)
      OP_ENQ:          return !full;
      OP_DEQ, OP_REPL: return !empty;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pq_arbiter_if.sv
// rtl/pq_arbiter_if.sv - client request/response bundle shared by N clients
interface pq_arbiter_if #(
  parameter int N = 4
);
  import pq_pkg::*;

  localparam int ID_W = $clog2(N);

  logic [N-1:0]      req_valid;
  logic [2*N-1:0]    req_op;
  logic [KV_W*N-1:0] req_kv;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [KV_W-1:0]   rsp_kv;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_kv,
    input  req_ready, rsp_valid, rsp_id, rsp_kv, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_kv,
    output req_ready, rsp_valid, rsp_id, rsp_kv, rsp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after ptr_i
module rr_arbiter #(
  parameter int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  input  logic            en_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_idx_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (en_i && !found && req_i[idx]) begin
        found          = 1'b1;
        gnt_o[idx]     = 1'b1;
        gnt_idx_o      = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pq_arbiter.sv
// rtl/pq_arbiter.sv - serialises N clients onto one shared priority queue,
// one command in flight, tagged registered responses.
module pq_arbiter
  import pq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  pq_arbiter_if.slave     cl,
  output logic            pq_enq_o,
  output logic            pq_deq_o,
  output logic [KV_W-1:0] pq_kvi_o,
  input  logic [KV_W-1:0] pq_kvo_i,
  input  logic            pq_full_i,
  input  logic            pq_empty_i,
  input  logic            pq_busy_i
);

  localparam int ID_W = $clog2(N);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  pq_op_t          op_q, op_d;
  kv_t             kv_q, kv_d;
  logic [ID_W-1:0] id_q, id_d;
  kv_t             head_q, head_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [KV_W-1:0] rsp_kv_q, rsp_kv_d;
  logic            rsp_err_q, rsp_err_d;

  logic            arb_en;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_idx;
  int              sel;
  pq_op_t          gnt_op;

  rr_arbiter #(.N(N)) u_rr (
    .req_i     (cl.req_valid),
    .ptr_i     (rr_ptr_q),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign sel    = int'(gnt_idx);
  assign gnt_op = pq_op_t'(cl.req_op[2*sel +: 2]);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_d         = op_q;
    kv_d         = kv_q;
    id_d         = id_q;
    head_d       = head_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = '0;
    rsp_kv_d     = '0;
    rsp_err_d    = 1'b0;
    arb_en       = 1'b0;
    pq_enq_o     = 1'b0;
    pq_deq_o     = 1'b0;
    pq_kvi_o     = '0;
    cl.req_ready = '0;
    unique case (state_q)
      ST_ARB: begin
        arb_en = !pq_busy_i;
        if (|gnt) begin
          cl.req_ready = gnt;
          op_d         = gnt_op;
          kv_d         = cl.req_kv[KV_W*sel +: KV_W];
          id_d         = gnt_idx;
          rr_ptr_d     = gnt_idx;
          head_d       = pq_kvo_i;
          if (op_is_legal(gnt_op, pq_full_i, pq_empty_i)) begin
            state_d = ST_ISSUE;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_idx;
            rsp_err_d   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        pq_enq_o = (op_q == OP_ENQ) || (op_q == OP_REPL);
        pq_deq_o = (op_q == OP_DEQ) || (op_q == OP_REPL);
        pq_kvi_o = kv_q;
        state_d  = ST_HOLD;
      end
      // The queue only raises busy the cycle after it accepts, so skip one look.
      ST_HOLD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!pq_busy_i) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_kv_d    = (op_q == OP_ENQ) ? pq_kvo_i : head_q;
        end
      end
      ST_RESP: state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= ID_W'(N-1);
      op_q        <= OP_NOP;
      kv_q        <= '0;
      id_q        <= '0;
      head_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_kv_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      kv_q        <= kv_d;
      id_q        <= id_d;
      head_q      <= head_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_kv_q    <= rsp_kv_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cl.rsp_valid = rsp_valid_q;
  assign cl.rsp_id    = rsp_id_q;
  assign cl.rsp_kv    = rsp_kv_q;
  assign cl.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_pq_arbiter.sv
// tb/tb_pq_arbiter.sv - behavioural queue + transaction model bench for pq_arbiter
module tb_pq_arbiter;
  import pq_pkg::*;

  localparam int N    = 4;
  localparam int ID_W = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pq_arbiter_if #(.N(N)) cl();

  logic            pq_enq, pq_deq;
  logic [KV_W-1:0] pq_kvi;
  logic [KV_W-1:0] pq_kvo   = '0;
  logic            pq_full  = 1'b0;
  logic            pq_empty = 1'b1;
  logic            pq_busy  = 1'b0;

  pq_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .cl         (cl),
    .pq_enq_o   (pq_enq),
    .pq_deq_o   (pq_deq),
    .pq_kvi_o   (pq_kvi),
    .pq_kvo_i   (pq_kvo),
    .pq_full_i  (pq_full),
    .pq_empty_i (pq_empty),
    .pq_busy_i  (pq_busy)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural priority queue: sorted by key, equal keys keep arrival order.
  kv_t q_mem[$];
  int  busy_left = 0;

  task automatic q_insert(input kv_t e);
    int pos;
    pos = q_mem.size();
    for (int i = q_mem.size() - 1; i >= 0; i--)
      if (q_mem[i].key > e.key) pos = i;
    q_mem.insert(pos, e);
  endtask

  task automatic dev_outputs();
    pq_kvo   = (q_mem.size() > 0) ? q_mem[0] : '0;
    pq_empty = (q_mem.size() == 0);
    pq_full  = (q_mem.size() == PQ_CAPACITY);
  endtask

  // Transaction model state.
  int   cyc = 0;
  logic chk_en = 1'b0;
  logic inflight = 1'b0;
  int   last_g = N - 1;
  int   exp_cmd_cyc = -1, exp_rsp_cyc = -1, exp_id = 0;
  logic exp_enq = 1'b0, exp_deq = 1'b0, exp_err = 1'b0;
  kv_t  exp_kv_in = '0, exp_rsp_kv = '0;
  int   planned_b = 1;
  int   force_b = 0;

  logic         cmd_enq = 1'b0, cmd_deq = 1'b0, rst_s = 1'b1;
  kv_t          cmd_kv = '0;
  logic [N-1:0] granted_s = '0;
  logic [N-1:0] exp_gnt;
  logic         m_found, m_legal, rv;
  int           m_c, m_g;
  pq_op_t       m_op;
  kv_t          m_kv;

  int   rsp_count = 0, enq_pulses = 0, deq_pulses = 0;
  int   last_rsp_id = 0, last_acc_cyc = 0, last_rsp_cyc = 0;
  kv_t  last_rsp_kv = '0;
  logic last_rsp_err = 1'b0;
  int   grant_log[$];

  always @(negedge clk) begin
    cyc++;
    rst_s     = rst;
    cmd_enq   = pq_enq;
    cmd_deq   = pq_deq;
    cmd_kv    = pq_kvi;
    granted_s = cl.req_ready;
    if (chk_en) begin
      exp_gnt = '0;
      m_found = 1'b0;
      if (!inflight && !pq_busy) begin
        for (int k = 1; k <= N; k++) begin
          m_c = (last_g + k) % N;
          if (!m_found && cl.req_valid[m_c]) begin
            exp_gnt[m_c] = 1'b1;
            m_found = 1'b1;
          end
        end
      end
      check("req_ready", cl.req_ready, exp_gnt);
      check("pq_enq", pq_enq, (cyc == exp_cmd_cyc) && exp_enq);
      check("pq_deq", pq_deq, (cyc == exp_cmd_cyc) && exp_deq);
      check("pq_kvi", pq_kvi, (cyc == exp_cmd_cyc) ? exp_kv_in : '0);
      rv = (cyc == exp_rsp_cyc);
      check("rsp_valid", cl.rsp_valid, rv);
      check("rsp_id", cl.rsp_id, rv ? ID_W'(exp_id) : '0);
      check("rsp_kv", cl.rsp_kv, rv ? exp_rsp_kv : '0);
      check("rsp_err", cl.rsp_err, rv && exp_err);
      if (pq_enq || pq_deq) check("cmd_while_busy", pq_busy, 1'b0);
      if (pq_enq) enq_pulses++;
      if (pq_deq) deq_pulses++;
      if (cl.rsp_valid) begin
        rsp_count++;
        last_rsp_id  = int'(cl.rsp_id);
        last_rsp_kv  = cl.rsp_kv;
        last_rsp_err = cl.rsp_err;
        last_rsp_cyc = cyc;
      end
      if (rv) inflight = 1'b0;
      if (m_found) begin
        m_g = 0;
        for (int i = 0; i < N; i++) if (exp_gnt[i]) m_g = i;
        last_g = m_g;
        grant_log.push_back(m_g);
        inflight = 1'b1;
        last_acc_cyc = cyc;
        m_op = pq_op_t'(cl.req_op[2*m_g +: 2]);
        m_kv = cl.req_kv[KV_W*m_g +: KV_W];
        m_legal = (m_op == OP_ENQ && !pq_full) ||
                  ((m_op == OP_DEQ || m_op == OP_REPL) && !pq_empty);
        exp_id = m_g;
        if (!m_legal) begin
          exp_rsp_cyc = cyc + 1;
          exp_err     = 1'b1;
          exp_rsp_kv  = '0;
          exp_cmd_cyc = -1;
        end else begin
          planned_b   = (force_b > 0) ? force_b : int'($urandom_range(1, 3));
          exp_cmd_cyc = cyc + 1;
          exp_rsp_cyc = cyc + 3 + planned_b;
          exp_err     = 1'b0;
          exp_enq     = (m_op == OP_ENQ) || (m_op == OP_REPL);
          exp_deq     = (m_op == OP_DEQ) || (m_op == OP_REPL);
          exp_kv_in   = m_kv;
          if (m_op == OP_ENQ)
            exp_rsp_kv = (q_mem.size() == 0 || m_kv.key < q_mem[0].key) ? m_kv : q_mem[0];
          else
            exp_rsp_kv = q_mem[0];
        end
      end
      if (rst_s) begin
        inflight    = 1'b0;
        last_g      = N - 1;
        exp_cmd_cyc = -1;
        exp_rsp_cyc = -1;
      end
    end
  end

  // Queue device: accepts a command at the clock edge, busy for planned_b cycles after.
  always @(posedge clk) begin
    #1;
    if (rst_s) begin
      q_mem.delete();
      busy_left = 0;
      pq_busy   = 1'b0;
    end else if (cmd_enq || cmd_deq) begin
      if (cmd_deq && q_mem.size() > 0) void'(q_mem.pop_front());
      if (cmd_enq && q_mem.size() < PQ_CAPACITY) q_insert(cmd_kv);
      busy_left = planned_b - 1;
      pq_busy   = 1'b1;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      pq_busy = !inflight && ($urandom_range(0, 9) == 0);
    end
    dev_outputs();
  end

  task automatic set_req(input int c, input pq_op_t op, input int key, input int val);
    cl.req_op[2*c +: 2]       = op;
    cl.req_kv[KV_W*c +: KV_W] = {KEY_WIDTH'(key), VAL_WIDTH'(val)};
  endtask

  task automatic send(input int c, input pq_op_t op, input int key);
    int start, t;
    @(posedge clk); #1;
    set_req(c, op, key, c);
    cl.req_valid[c] = 1'b1;
    start = rsp_count;
    t = 0;
    while (rsp_count == start && t < 60) begin
      @(posedge clk); #1;
      t++;
      if (granted_s[c]) cl.req_valid[c] = 1'b0;
    end
    cl.req_valid[c] = 1'b0;
    check("send_rsp_seen", rsp_count != start, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    cl.req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_random(input int ncyc);
    int r;
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk); #1;
      for (int c = 0; c < N; c++) begin
        if (granted_s[c]) cl.req_valid[c] = 1'b0;
        else if (cl.req_valid[c] && $urandom_range(0, 19) == 0) cl.req_valid[c] = 1'b0;
        else if (!cl.req_valid[c] && $urandom_range(0, 3) == 0) begin
          r = int'($urandom_range(0, 19));
          set_req(c, (r == 0) ? OP_NOP : (r < 10) ? OP_ENQ : (r < 16) ? OP_DEQ : OP_REPL,
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
          cl.req_valid[c] = 1'b1;
        end
      end
    end
    cl.req_valid = '0;
  endtask

  initial begin
    int n0, t;
    cl.req_valid = '0;
    cl.req_op    = '0;
    cl.req_kv    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    force_b = 1;

    // Single enqueue into an empty queue.
    do_reset();
    enq_pulses = 0;
    send(0, OP_ENQ, 5);
    check("enq1_id", last_rsp_id, 0);
    check("enq1_key", last_rsp_kv.key, 5);
    check("enq1_err", last_rsp_err, 1'b0);
    check("enq1_pulses", enq_pulses, 1);
    check("enq1_latency", last_rsp_cyc - last_acc_cyc, 4);

    // Three enqueues then two dequeues.
    do_reset();
    send(1, OP_ENQ, 9);
    send(1, OP_ENQ, 3);
    send(1, OP_ENQ, 7);
    send(2, OP_DEQ, 0);
    check("deq1_id", last_rsp_id, 2);
    check("deq1_key", last_rsp_kv.key, 3);
    send(2, OP_DEQ, 0);
    check("deq2_key", last_rsp_kv.key, 7);

    // Dequeue from an empty queue.
    do_reset();
    deq_pulses = 0;
    send(0, OP_DEQ, 0);
    check("deq_empty_err", last_rsp_err, 1'b1);
    check("deq_empty_latency", last_rsp_cyc - last_acc_cyc, 1);
    check("deq_empty_pulses", deq_pulses, 0);
    check("deq_empty_kv", last_rsp_kv, 0);

    // Enqueue into a full queue.
    for (int i = 0; i < PQ_CAPACITY; i++) send(0, OP_ENQ, 10 + i);
    enq_pulses = 0;
    send(1, OP_ENQ, 2);
    check("full_err", last_rsp_err, 1'b1);
    check("full_pulses", enq_pulses, 0);
    check("full_size", q_mem.size(), PQ_CAPACITY);
    check("full_head", q_mem[0].key, 10);

    // Round robin with every client holding ENQ from reset.
    @(posedge clk); #1;
    cl.req_valid = '0;
    rst = 1'b1;
    for (int c = 0; c < N; c++) set_req(c, OP_ENQ, 20 + c, c);
    @(posedge clk); #1;
    rst = 1'b0;
    grant_log.delete();
    cl.req_valid = '1;
    repeat (40) @(posedge clk);
    #1;
    cl.req_valid = '0;
    check("rr_count", grant_log.size() >= 5, 1'b1);
    if (grant_log.size() >= 5) begin
      check("rr_g0", grant_log[0], 0);
      check("rr_g1", grant_log[1], 1);
      check("rr_g2", grant_log[2], 2);
      check("rr_g3", grant_log[3], 3);
      check("rr_g4", grant_log[4], 0);
    end

    // REPLACE returns the old minimum.
    do_reset();
    send(0, OP_ENQ, 4);
    send(0, OP_ENQ, 8);
    send(3, OP_REPL, 6);
    check("repl_id", last_rsp_id, 3);
    check("repl_key", last_rsp_kv.key, 4);
    check("repl_err", last_rsp_err, 1'b0);
    send(1, OP_DEQ, 0);
    check("repl_deq1", last_rsp_kv.key, 6);
    send(1, OP_DEQ, 0);
    check("repl_deq2", last_rsp_kv.key, 8);

    // Reset while a DEQ waits on busy.
    do_reset();
    send(0, OP_ENQ, 2);
    force_b = 6;
    @(posedge clk); #1;
    set_req(2, OP_DEQ, 0, 0);
    cl.req_valid[2] = 1'b1;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!granted_s[2] && t < 30);
    check("midrst_grant", granted_s[2], 1'b1);
    cl.req_valid[2] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n0 = rsp_count;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_rsp_valid", cl.rsp_valid, 1'b0);
    check("midrst_enq", pq_enq, 1'b0);
    check("midrst_deq", pq_deq, 1'b0);
    check("midrst_kvi", pq_kvi, 0);
    check("midrst_rsp_kv", cl.rsp_kv, 0);
    repeat (10) @(posedge clk);
    check("midrst_no_rsp", rsp_count, n0);
    force_b = 1;
    send(0, OP_ENQ, 1);
    check("midrst_after_key", last_rsp_kv.key, 1);
    check("midrst_after_err", last_rsp_err, 1'b0);

    // Randomised traffic against the model.
    force_b = 0;
    do_reset();
    run_random(3000);
    repeat (20) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pq_arbiter.md
Name: pq_arbiter

Overview:
- Shares one priority-queue instance (pq_if device side: enq/deq/kvi/kvo/full/empty/busy) among N independent clients.
- Each client issues ENQ, DEQ or REPLACE requests over valid/ready.
- A round-robin grant serialises requests, and one command is in flight at a time.
- Each completed command produces a tagged response carrying the removed or current head; illegal commands get an error response without touching the queue.

Parameters:
- N, 4, number of clients (N >= 2); ID_W = $clog2(N) is a local param.
- KV_W, KEY_WIDTH+VAL_WIDTH, width of one key/value entry, taken from pq_pkg.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; the same rst also drives the shared queue
- req_valid  in  N  per-client request valid
- req_op  in  2*N  per-client pq_op_t, client i at bits [2i+1:2i]
- req_kv  in  KV_W*N  per-client entry for ENQ/REPLACE, client i at slice i
- req_ready  out  N  one-hot pulse marking the request accepted this cycle
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  ID_W  client the response belongs to
- rsp_kv  out  KV_W  returned entry
- rsp_err  out  1  command rejected (full/empty/NOP)
- pq_enq  out  1  to queue enq
- pq_deq  out  1  to queue deq
- pq_kvi  out  KV_W  to queue kvi
- pq_kvo  in  KV_W  queue head
- pq_full  in  1  queue full
- pq_empty  in  1  queue empty
- pq_busy  in  1  queue busy

Behaviour:
- Reset: state=ARB, rr_ptr=N-1, all outputs 0, pq_kvi=0. The queue resets in the same cycle; any command in flight is abandoned and no response is produced for it.
- Op encoding (pq_op_t): OP_NOP=0, OP_ENQ=1, OP_DEQ=2, OP_REPL=3. REPLACE drives pq_enq and pq_deq together.
- ARB:
  - If pq_busy=0 and any req_valid is set, grant the first valid client searching from rr_ptr+1 modulo N.
  - Assert req_ready[g] in this cycle only.
  - Latch op, kv and id=g; set rr_ptr=g; latch head=pq_kvo.
  - Legality check, using pq_full/pq_empty sampled this cycle:
    - ENQ with full, DEQ/REPL with empty, or NOP: go to RESP with err=1.
    - Otherwise: go to ISSUE.
  - With no valid request, stay in ARB; rr_ptr is unchanged.
- ISSUE: drive pq_enq/pq_deq per the op for exactly one cycle, with pq_kvi = latched kv. Then go to HOLD.
- HOLD: one cycle, pq_busy ignored (the queue raises busy the cycle after acceptance). Then go to WAIT.
- WAIT: stay while pq_busy=1. On pq_busy=0, go to RESP.
- RESP: rsp_valid=1, rsp_id=id, rsp_err=err. Then go to ARB.
  - rsp_kv for DEQ/REPL: the latched head (the removed minimum).
  - rsp_kv for ENQ: current pq_kvo (the new head).
  - rsp_kv for err: 0.
- Latency:
  - Request accept to rsp_valid is 4 cycles plus the number of extra busy cycles.
  - Error path: accept to rsp_valid is 1 cycle.
  - A new grant is possible the cycle after RESP.
- Fairness: a client holding req_valid is granted within N grants. A client may deassert req_valid before it is granted with no effect.
- pq_enq and pq_deq are 0 in every state except ISSUE. The arbiter never issues a command while pq_busy=1.
- rsp_* outputs are registered. rsp_kv, rsp_id and rsp_err are 0 whenever rsp_valid=0.

Decomposition:
- pq_pkg gains pq_op_t and the OP_* constants; kv_t, KEY_WIDTH, VAL_WIDTH and PQ_CAPACITY already live there.
- One sub-module, rr_arbiter (parameter N). Inputs: req vector, ptr, enable. Outputs: one-hot grant and grant index, combinational, with the pointer held in the parent.
- The top level instantiates rr_arbiter and the 5-state FSM (ARB, ISSUE, HOLD, WAIT, RESP).

Test Plan:
- Single enqueue: client 0 sends ENQ key=5 into an empty queue -> req_ready[0] pulses, pq_enq high for 1 cycle, rsp_valid with id=0, kv.key=5, err=0.
- Three enqueues then dequeue: client 1 enqueues keys 9, 3, 7, then client 2 sends DEQ -> rsp id=2, key=3; a second DEQ returns key=7.
- Error paths:
  - DEQ on an empty queue -> rsp_err=1 within 1 cycle of accept, pq_deq never asserted.
  - Fill to PQ_CAPACITY, then ENQ -> rsp_err=1 and queue contents unchanged.
- Round robin: all 4 clients hold ENQ continuously from reset -> grant order 0,1,2,3,0, and no two commands overlap (pq_enq only while pq_busy=0).
- REPLACE: queue holds {4,8}, client 3 sends REPL key=6 -> rsp key=4, subsequent DEQs return 6 then 8.
- Reset mid-operation: assert rst during WAIT of a DEQ -> no rsp_valid, all outputs 0 the next cycle, state=ARB, and a following ENQ key=1 completes normally.
